// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing a 16:1 single-bit mux between 16 requesters.
// Grants are held until done, request drop, or the MAX_HOLD cycle limit.
module mux16_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 8
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] req,
  input  logic        done,
  input  logic [15:0] W,
  output logic [3:0]  S,
  output logic [15:0] grant,
  output logic        valid,
  output logic        f
);

  localparam int unsigned N  = 16;
  localparam int unsigned SW = 4;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   win_idx;
  logic            win_found;
  logic            release_c;

  // Rotating priority search starting at ptr, wrapping mod 16
  always_comb begin
    win_idx   = ptr_q;
    win_found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!win_found && req[ptr_q + SW'(k)]) begin
        win_idx   = ptr_q + SW'(k);
        win_found = 1'b1;
      end
    end
  end

  assign release_c = done | ~req[s_q] | (cnt_q == CW'(MAX_HOLD - 1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      s_q     <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (win_found) state_d = GRANT;
      GRANT: if (release_c) state_d = IDLE;
    endcase
  end

  // Register updates; S deliberately keeps its last value across a release
  always_comb begin
    s_d     = s_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          s_d     = win_idx;
          grant_d = N'(1) << win_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = s_q + SW'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  assign S     = s_q;
  assign grant = grant_q;
  assign valid = valid_q;
  assign f     = valid_q & W[s_q];

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: reset, vector table, hand sequences and a random run
// against a queue-free behavioural model of the round-robin rules.
module tb_mux16_rr_arbiter;

  localparam int unsigned MH = 8;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] req;
  logic        done;
  logic [15:0] W;
  logic [3:0]  S, S1;
  logic [15:0] grant, grant1;
  logic        valid, valid1, f, f1;

  int n_chk  = 0;
  int n_fail = 0;

  mux16_rr_arbiter #(.MAX_HOLD(MH), .CW(8)) u_dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .done(done), .W(W),
    .S(S), .grant(grant), .valid(valid), .f(f)
  );

  mux16_rr_arbiter #(.MAX_HOLD(1), .CW(8)) u_dut1 (
    .Clock(Clock), .Resetn(Resetn), .req(req), .done(done), .W(W),
    .S(S1), .grant(grant1), .valid(valid1), .f(f1)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: who is served, how long, and where the search starts next
  bit m_busy;
  int m_cur, m_ptr, m_held;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_busy = 0; m_cur = 0; m_ptr = 0; m_held = 0;
    end else if (!m_busy) begin
      if (req != 16'h0) begin
        for (int k = 0; k < 16; k++) begin
          if (req[(m_ptr + k) % 16]) begin
            m_cur = (m_ptr + k) % 16;
            break;
          end
        end
        m_busy = 1; m_held = 1;
      end
    end else begin
      if (done || !req[m_cur] || m_held == MH) begin
        m_busy = 0;
        m_ptr  = (m_cur + 1) % 16;
      end else begin
        m_held++;
      end
    end
  end

  function automatic logic [21:0] pk(logic [3:0] s, logic [15:0] g, logic v, logic ff);
    return {s, g, v, ff};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0; req = '0; done = 1'b0; W = '0;
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [15:0] w;
    logic [3:0]  s;
    logic [15:0] g;
    logic        v;
    logic        f;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int t;
    logic [3:0] es;
    logic       ev;

    tbl[0]  = '{16'h0000, 1'b0, 16'h0000, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{16'h0001, 1'b0, 16'h0001, 4'd0,  16'h0001, 1'b1, 1'b1};
    tbl[2]  = '{16'h0001, 1'b0, 16'h0001, 4'd0,  16'h0001, 1'b1, 1'b1};
    tbl[3]  = '{16'h0001, 1'b1, 16'h0001, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{16'h0001, 1'b0, 16'h0000, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[5]  = '{16'h0000, 1'b0, 16'h0000, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[6]  = '{16'h8001, 1'b0, 16'h8000, 4'd15, 16'h8000, 1'b1, 1'b1};
    tbl[7]  = '{16'h8001, 1'b1, 16'h8000, 4'd15, 16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{16'h8001, 1'b0, 16'h8000, 4'd0,  16'h0001, 1'b1, 1'b0};
    tbl[9]  = '{16'h8001, 1'b1, 16'h8000, 4'd0,  16'h0000, 1'b0, 1'b0};
    tbl[10] = '{16'h8001, 1'b0, 16'h8000, 4'd15, 16'h8000, 1'b1, 1'b1};
    tbl[11] = '{16'h0020, 1'b0, 16'h0020, 4'd15, 16'h0000, 1'b0, 1'b0};
    tbl[12] = '{16'h0020, 1'b0, 16'h0020, 4'd5,  16'h0020, 1'b1, 1'b1};
    tbl[13] = '{16'h0060, 1'b0, 16'h0060, 4'd5,  16'h0020, 1'b1, 1'b1};
    tbl[14] = '{16'h0060, 1'b0, 16'h0020, 4'd5,  16'h0020, 1'b1, 1'b1};
    tbl[15] = '{16'h0040, 1'b0, 16'h0040, 4'd5,  16'h0000, 1'b0, 1'b0};
    tbl[16] = '{16'h0040, 1'b1, 16'h0040, 4'd6,  16'h0040, 1'b1, 1'b1};
    tbl[17] = '{16'h0040, 1'b1, 16'h0040, 4'd6,  16'h0000, 1'b0, 1'b0};

    // Reset held 3 cycles, then idle with req=0
    Resetn = 1'b0; req = '0; done = 1'b0; W = '0;
    #1 chk("reset_out", 32'(pk(S, grant, valid, f)), 32'(pk(4'd0, 16'h0, 1'b0, 1'b0)));
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      chk("idle_after_reset", 32'(pk(S, grant, valid, f)), 32'(pk(4'd0, 16'h0, 1'b0, 1'b0)));
    end

    for (int i = 0; i < 18; i++) begin
      req = tbl[i].req; done = tbl[i].done; W = tbl[i].w;
      @(negedge Clock);
      chk($sformatf("vec%0d", i), 32'(pk(S, grant, valid, f)),
          32'(pk(tbl[i].s, tbl[i].g, tbl[i].v, tbl[i].f)));
    end

    // All requesting: 8-cycle grants in order with one idle cycle between;
    // the MAX_HOLD=1 instance alternates grant/idle
    do_reset();
    req = 16'hFFFF; done = 1'b0;
    for (t = 0; t < 17 * 9; t++) begin
      W = 16'($urandom);
      @(negedge Clock);
      es = 4'((t / 9) % 16);
      ev = (t % 9) < 8;
      chk("ffff_mh8", 32'(pk(S, grant, valid, f)),
          32'(pk(es, ev ? (16'h1 << es) : 16'h0, ev, ev & W[es])));
      es = 4'((t / 2) % 16);
      ev = (t % 2) == 0;
      chk("ffff_mh1", 32'(pk(S1, grant1, valid1, f1)),
          32'(pk(es, ev ? (16'h1 << es) : 16'h0, ev, ev & W[es])));
    end

    // Asynchronous reset mid-grant clears outputs and the priority pointer
    do_reset();
    req = 16'h0400;
    @(negedge Clock);
    chk("pre_s10", 32'(pk(S, grant, valid, f)), 32'(pk(4'd10, 16'h0400, 1'b1, 1'b0)));
    done = 1'b1;
    @(negedge Clock);
    chk("pre_rel", 32'(pk(S, grant, valid, f)), 32'(pk(4'd10, 16'h0000, 1'b0, 1'b0)));
    done = 1'b0; req = 16'h0200; W = 16'h0200;
    @(negedge Clock);
    chk("grant_s9", 32'(pk(S, grant, valid, f)), 32'(pk(4'd9, 16'h0200, 1'b1, 1'b1)));
    repeat (4) @(negedge Clock);
    chk("hold_s9", 32'(pk(S, grant, valid, f)), 32'(pk(4'd9, 16'h0200, 1'b1, 1'b1)));
    #2 Resetn = 1'b0;
    #1 chk("async_rst", 32'(pk(S, grant, valid, f)), 32'(pk(4'd0, 16'h0, 1'b0, 1'b0)));
    @(negedge Clock);
    Resetn = 1'b1; req = 16'h0401; W = 16'h0001;
    @(negedge Clock);
    chk("ptr_restart", 32'(pk(S, grant, valid, f)), 32'(pk(4'd0, 16'h0001, 1'b1, 1'b1)));

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 16'($urandom & $urandom);
      done = ($urandom_range(0, 9) == 0);
      W    = 16'($urandom);
      @(negedge Clock);
      chk("rand_model", 32'(pk(S, grant, valid, f)),
          32'(pk(4'(m_cur), m_busy ? (16'h1 << m_cur) : 16'h0, m_busy, m_busy & W[m_cur])));
      chk("rand_onehot", 32'($onehot0(grant)), 32'd1);
      chk("rand_grant_s", 32'(grant[S]), 32'(valid));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the team's 16:1 single-bit mux (two 8:1 stages plus a 2:1 stage).
- Shares the mux between 16 requesters, one per data input W[i].
- Drives the 4-bit select S: S[2:0] goes to both 8:1 stages and S[3] goes to the 2:1 stage.
- Holds each grant until the requester is done, drops its request, or hits a hold-time limit.

Parameters:
- MAX_HOLD, 8, maximum cycles one requester may hold a grant (legal range 1..255).
- CW, 8, width of the hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  asynchronous active-low reset.
- req  input  16  request lines; req[i] requests mux input W[i].
- done  input  1  granted requester's release pulse; sampled only in GRANT.
- W  input  16  mux data inputs, passed through to the selected output.
- S  output  4  registered select code driven to the mux tree.
- grant  output  16  registered one-hot grant; all zero when idle.
- valid  output  1  registered; high while a grant is active.
- f  output  1  combinational, equal to W[S] when valid=1, else 0.

Behaviour:
- Reset (Resetn=0, asynchronous, immediate):
  - state=IDLE, S=0, grant=0, valid=0, f=0.
  - Priority pointer ptr=0, hold counter cnt=0.
  - Reset asserted mid-grant drops the grant immediately; no done is required afterwards.
- State machine, two states:
  - IDLE:
    - If req==0: stay in IDLE, outputs unchanged at zero/idle values.
    - Otherwise select the winner idx = first i with req[i]=1, searching ptr, ptr+1, ... 15, 0, ... ptr-1 (mod 16).
    - On the clock edge: S<=idx, grant<=one-hot(idx), valid<=1, cnt<=0, state<=GRANT.
  - GRANT, evaluated each edge:
    - Release when any of these holds: done=1, req[S]=0, or cnt==MAX_HOLD-1.
    - On release: grant<=0, valid<=0, ptr<=(S+1) mod 16, cnt<=0, state<=IDLE. S keeps its last value.
    - Otherwise: cnt<=cnt+1 and all other registers hold.
- Latency and timing:
  - req sampled at edge n produces grant/valid high after edge n.
  - A grant lasts at least 1 and at most MAX_HOLD cycles.
  - After every release there is exactly one idle cycle (valid=0) before the next grant.
- Fairness:
  - The requester just served has the lowest priority next round.
  - Any persistently requesting line is granted within 15 grants.
  - ptr wraps 15->0.
- Simultaneous events:
  - done, req drop and timeout in the same cycle cause a single release; ptr advances once.
  - Requests that change during GRANT do not preempt the current grant.
  - done asserted while in IDLE is ignored.
- Invariants:
  - grant is always zero or one-hot.
  - grant[S]==valid.
  - f never reflects an ungranted input.
- MAX_HOLD=1: every grant lasts exactly one cycle, so valid toggles 1,0,1,0 under continuous requests.

Test Plan:
- Hold reset low for 3 cycles, then release with req=0 -> S=0, grant=0, valid=0, f=0 for 10 cycles.
- req=16'h0001 with done pulsed on the 3rd grant cycle:
  - grant=0x0001 and valid=1 one edge after req.
  - Release occurs on the done edge; next cycle valid=0; ptr becomes 1.
- req=16'hFFFF held with done=0 and MAX_HOLD=8:
  - Grants go to S=0,1,2,...,15,0 in order.
  - Each grant lasts 8 cycles, followed by 1 idle cycle.
- req=16'h8001 with ptr=1, done each grant:
  - Grant sequence is S=15, then 0, then 15.
  - The wrap-around search works.
- Grant S=5 with W=16'h0020:
  - f=1 while valid.
  - Dropping req[5] causes release on the next edge and f=0.
  - Toggling W[6] during the grant does not change f.
- Assert Resetn=0 mid-grant (S=9, cnt=4) -> grant, valid and S clear immediately; after reset, arbitration restarts from ptr=0.
